// File: rtl/lfsr_prbs.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_prbs
// Brief    : Fibonacci-LFSR PRBS generator plus self-synchronising checker
//            that hunts for lock and counts bit errors.
// Revision : 1.0
// ============================================================================
module lfsr_prbs #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      NBITS    = 8,
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
    parameter int unsigned      SYNC_LEN = 2 * WIDTH,
    parameter int unsigned      LOSS_THR = NBITS / 2,
    parameter int unsigned      ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] taps,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             en,
    output logic [NBITS-1:0] gen_data,
    output logic             gen_valid,
    output logic [WIDTH-1:0] sr,
    output logic             lockup,
    input  logic [NBITS-1:0] din,
    input  logic             din_valid,
    input  logic             clr_err,
    output logic             lock,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_pulse
);

    localparam int unsigned c_fill_w  = $clog2(WIDTH + 1);
    localparam int unsigned c_match_w = $clog2(SYNC_LEN + 1);
    localparam int unsigned c_nerr_w  = $clog2(NBITS + 1);
    localparam int unsigned c_sum_w   = ((ERR_W > c_nerr_w) ? ERR_W : c_nerr_w) + 1;

    localparam logic [c_fill_w-1:0]  c_fill_full = c_fill_w'(WIDTH);
    localparam logic [c_match_w-1:0] c_sync_len  = c_match_w'(SYNC_LEN);
    localparam logic [c_sum_w-1:0]   c_err_max   = c_sum_w'({ERR_W{1'b1}});

    // ------------------------------------------------------------------
    // Generator
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_sr;
    logic [NBITS-1:0] r_gen_data;
    logic             r_gen_valid;
    logic             r_lockup;

    logic             w_gen_zero;
    logic [WIDTH-1:0] w_gen_start;
    logic [WIDTH-1:0] w_gen_next;
    logic [NBITS-1:0] w_gen_bits;

    assign w_gen_zero  = (r_sr == '0);
    assign w_gen_start = w_gen_zero ? SEED : r_sr;

    always_comb begin : p_gen_unroll
        logic [WIDTH-1:0] w_st;
        w_st       = w_gen_start;
        w_gen_bits = '0;
        for (int unsigned i = 0; i < NBITS; i++) begin
            w_gen_bits[i] = w_st[0];
            w_st          = {^(w_st & taps), w_st[WIDTH-1:1]};
        end
        w_gen_next = w_st;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr        <= SEED;
            r_gen_data  <= '0;
            r_gen_valid <= 1'b0;
            r_lockup    <= 1'b0;
        end else begin
            r_gen_valid <= 1'b0;
            r_lockup    <= 1'b0;
            if (load) begin
                if (seed_in != '0) begin
                    r_sr <= seed_in;
                end else begin
                    r_sr     <= SEED;
                    r_lockup <= 1'b1;
                end
            end else if (en) begin
                r_sr        <= w_gen_next;
                r_gen_data  <= w_gen_bits;
                r_gen_valid <= 1'b1;
                r_lockup    <= w_gen_zero;
            end
        end
    end

    assign sr        = r_sr;
    assign gen_data  = r_gen_data;
    assign gen_valid = r_gen_valid;
    assign lockup    = r_lockup;

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_t;

    chk_state_t           r_state;
    logic [WIDTH-1:0]     r_cr;
    logic [c_fill_w-1:0]  r_fill;
    logic [c_match_w-1:0] r_match;
    logic                 r_lock;
    logic [ERR_W-1:0]     r_err_cnt;
    logic                 r_err_pulse;

    chk_state_t           w_state_nxt;
    logic [WIDTH-1:0]     w_cr_nxt;
    logic [c_fill_w-1:0]  w_fill_nxt;
    logic [c_match_w-1:0] w_match_nxt;
    logic [c_nerr_w-1:0]  w_nerr;
    logic [ERR_W-1:0]     w_err_base;
    logic [c_sum_w-1:0]   w_err_sum;
    logic [ERR_W-1:0]     w_err_sat;

    // Whole word is consumed bit-serially within one cycle, earliest bit first.
    always_comb begin : p_chk_word
        logic w_pred;
        w_pred      = 1'b0;
        w_cr_nxt    = r_cr;
        w_fill_nxt  = r_fill;
        w_match_nxt = r_match;
        w_nerr      = '0;
        for (int unsigned i = 0; i < NBITS; i++) begin
            w_pred = ^(w_cr_nxt & taps);
            if (r_state == ST_HUNT) begin
                if (w_fill_nxt == c_fill_full) begin
                    if (din[i] == w_pred) begin
                        if (w_match_nxt != c_sync_len) begin
                            w_match_nxt = w_match_nxt + c_match_w'(1);
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end else begin
                    w_fill_nxt = w_fill_nxt + c_fill_w'(1);
                end
                w_cr_nxt = {din[i], w_cr_nxt[WIDTH-1:1]};
            end else begin
                // Free-running prediction keeps a bad bit from corrupting later ones.
                if (din[i] != w_pred) begin
                    w_nerr = w_nerr + c_nerr_w'(1);
                end
                w_cr_nxt = {w_pred, w_cr_nxt[WIDTH-1:1]};
            end
        end

        w_state_nxt = r_state;
        if (r_state == ST_HUNT) begin
            if (w_match_nxt >= c_sync_len) begin
                w_state_nxt = ST_LOCKED;
            end
        end else if (32'(w_nerr) > LOSS_THR) begin
            w_state_nxt = ST_HUNT;
            w_fill_nxt  = '0;
            w_match_nxt = '0;
        end
    end

    assign w_err_base = clr_err ? '0 : r_err_cnt;
    assign w_err_sum  = c_sum_w'(w_err_base) + c_sum_w'(w_nerr);
    assign w_err_sat  = (w_err_sum > c_err_max) ? {ERR_W{1'b1}} : w_err_sum[ERR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_HUNT;
            r_cr        <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_lock      <= 1'b0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (din_valid) begin
                r_state     <= w_state_nxt;
                r_cr        <= w_cr_nxt;
                r_fill      <= w_fill_nxt;
                r_match     <= w_match_nxt;
                r_lock      <= (w_state_nxt == ST_LOCKED);
                r_err_cnt   <= w_err_sat;
                r_err_pulse <= (r_state == ST_LOCKED) && (w_nerr != '0);
            end else if (clr_err) begin
                r_err_cnt <= '0;
            end
        end
    end

    assign lock      = r_lock;
    assign err_cnt   = r_err_cnt;
    assign err_pulse = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prbs.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_prbs
// Brief    : Scoreboard bench for lfsr_prbs (generator period/lockup, and
//            generator looped into checker with error injection).
// Revision : 1.0
// ============================================================================
module tb_lfsr_prbs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: WIDTH=7, NBITS=8, ERR_W=4, generator looped to checker
    logic [6:0] taps_a = 7'h41;
    logic [6:0] seed_a = 7'h00;
    logic       load_a = 1'b0;
    logic       en_a   = 1'b0;
    logic       clr_a  = 1'b0;
    logic [7:0] inj_a  = 8'h00;
    logic [7:0] gd_a;
    logic [7:0] din_a;
    logic       gv_a, dv_a, lockup_a, lock_a, ep_a;
    logic [6:0] sr_a;
    logic [3:0] err_a;

    assign din_a = gd_a ^ inj_a;
    assign dv_a  = gv_a;

    lfsr_prbs #(.WIDTH(7), .NBITS(8), .SEED(7'h01), .ERR_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .taps(taps_a), .load(load_a), .seed_in(seed_a),
        .en(en_a), .gen_data(gd_a), .gen_valid(gv_a), .sr(sr_a), .lockup(lockup_a),
        .din(din_a), .din_valid(dv_a), .clr_err(clr_a), .lock(lock_a),
        .err_cnt(err_a), .err_pulse(ep_a)
    );

    // Instance B: WIDTH=7, NBITS=1, generator only
    logic [6:0]  taps_b = 7'h41;
    logic [6:0]  seed_b = 7'h00;
    logic        load_b = 1'b0;
    logic        en_b   = 1'b0;
    logic [0:0]  din_b  = 1'b0;
    logic        dv_b   = 1'b0;
    logic        clr_b  = 1'b0;
    logic [0:0]  gd_b;
    logic        gv_b, lockup_b, lock_b, ep_b;
    logic [6:0]  sr_b;
    logic [15:0] err_b;

    lfsr_prbs #(.WIDTH(7), .NBITS(1), .SEED(7'h01)) u_dut_b (
        .clk(clk), .rst(rst), .taps(taps_b), .load(load_b), .seed_in(seed_b),
        .en(en_b), .gen_data(gd_b), .gen_valid(gv_b), .sr(sr_b), .lockup(lockup_b),
        .din(din_b), .din_valid(dv_b), .clr_err(clr_b), .lock(lock_b),
        .err_cnt(err_b), .err_pulse(ep_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
        return {^(s & t), s[6:1]};
    endfunction

    typedef struct packed {
        logic       lock;
        logic [3:0] err;
        logic       pulse;
    } chk_t;

    logic [7:0] q_gen[$];
    chk_t       q_chk[$];

    // Reference state for instance A
    logic [6:0] m_sr    = 7'h01;
    logic       m_valid = 1'b0;
    logic       m_lock  = 1'b0;
    int         m_err   = 0;
    int         m_bits  = 0;

    // One clock of instance A: drive, push expectations, step, pop and compare.
    task automatic tick(input logic ev, input logic [7:0] inj, input logic clr);
        logic [7:0] w;
        logic [7:0] exp_w;
        int         nerr;
        chk_t       e;
        chk_t       exp_c;
        en_a  = ev;
        inj_a = inj;
        clr_a = clr;
        w     = 8'h00;
        if (ev) begin
            for (int k = 0; k < 8; k++) begin
                w[k] = m_sr[0];
                m_sr = lfsr_step(m_sr, taps_a);
            end
            q_gen.push_back(w);
        end
        nerr    = $countones(inj);
        e.pulse = 1'b0;
        if (clr) m_err = 0;
        if (m_valid) begin
            if (m_lock) begin
                m_err   = (m_err + nerr > 15) ? 15 : m_err + nerr;
                e.pulse = (nerr > 0);
                if (nerr > 4) begin
                    m_lock = 1'b0;
                    m_bits = 0;
                end
            end else begin
                // Clean stream: compared matches = bits seen beyond the 7-bit fill
                m_bits += 8;
                if (m_bits - 7 >= 14) m_lock = 1'b1;
            end
        end
        e.lock = m_lock;
        e.err  = 4'(m_err);
        q_chk.push_back(e);
        m_valid = ev;

        @(posedge clk);
        #1;
        check_eq("gen_valid", gv_a, ev);
        check_eq("sr", sr_a, m_sr);
        if (ev) begin
            exp_w = q_gen.pop_front();
            check_eq("gen_data", gd_a, exp_w);
        end
        exp_c = q_chk.pop_front();
        check_eq("lock", lock_a, exp_c.lock);
        check_eq("err_cnt", err_a, exp_c.err);
        check_eq("err_pulse", ep_a, exp_c.pulse);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sr", sr_a, 7'h01);
        check_eq("rst_gen_data", gd_a, 8'h00);
        check_eq("rst_gen_valid", gv_a, 1'b0);
        check_eq("rst_lockup", lockup_a, 1'b0);
        check_eq("rst_lock", lock_a, 1'b0);
        check_eq("rst_err_cnt", err_a, 4'h0);
        check_eq("rst_err_pulse", ep_a, 1'b0);
        check_eq("rst_sr_b", sr_b, 7'h01);
        rst = 1'b0;

        // Maximal-length period with NBITS=1
        en_b = 1'b1;
        for (int i = 1; i <= 127; i++) begin
            @(posedge clk);
            #1;
            check_eq("period", 32'(sr_b == 7'h01), 32'(i == 127));
        end
        en_b = 1'b0;

        // Zero seed load recovers to SEED with a lockup pulse
        load_b = 1'b1;
        seed_b = 7'h00;
        @(posedge clk);
        #1;
        load_b = 1'b0;
        check_eq("zload_sr", sr_b, 7'h01);
        check_eq("zload_lockup", lockup_b, 1'b1);
        check_eq("zload_valid", gv_b, 1'b0);
        @(posedge clk);
        #1;
        check_eq("lockup_one_cycle", lockup_b, 1'b0);

        // load has priority over en
        load_b = 1'b1;
        en_b   = 1'b1;
        seed_b = 7'h55;
        @(posedge clk);
        #1;
        check_eq("load_sr", sr_b, 7'h55);
        check_eq("load_valid", gv_b, 1'b0);
        check_eq("load_lockup", lockup_b, 1'b0);
        en_b   = 1'b0;
        seed_b = 7'h01;
        @(posedge clk);
        #1;
        load_b = 1'b0;
        check_eq("load_sr1", sr_b, 7'h01);

        // Degenerate taps drive the state to zero, next en restarts from SEED
        taps_b = 7'h40;
        en_b   = 1'b1;
        @(posedge clk);
        #1;
        check_eq("to_zero_sr", sr_b, 7'h00);
        check_eq("to_zero_bit", gd_b, 1'b1);
        check_eq("to_zero_lockup", lockup_b, 1'b0);
        check_eq("to_zero_valid", gv_b, 1'b1);
        @(posedge clk);
        #1;
        check_eq("restart_lockup", lockup_b, 1'b1);
        check_eq("restart_bit", gd_b, 1'b1);
        check_eq("restart_sr", sr_b, 7'h00);
        en_b = 1'b0;
        @(posedge clk);
        #1;
        check_eq("restart_lockup_end", lockup_b, 1'b0);
        check_eq("idle_valid", gv_b, 1'b0);

        // Instance A: generator words, acquisition, clean run
        tick(1'b1, 8'h00, 1'b0);
        check_eq("word0", gd_a, 8'h81);
        tick(1'b1, 8'h00, 1'b0);
        check_eq("word1", gd_a, 8'hBF);
        repeat (200) tick(1'b1, 8'h00, 1'b0);
        check_eq("lock_acq", lock_a, 1'b1);
        check_eq("clean_err", err_a, 4'h0);

        // Single bit error while locked
        tick(1'b1, 8'h08, 1'b0);
        check_eq("single_err", err_a, 4'h1);
        check_eq("single_lock", lock_a, 1'b1);
        repeat (5) tick(1'b1, 8'h00, 1'b0);

        // Five errors in one word exceed the loss threshold
        tick(1'b1, 8'h1F, 1'b0);
        check_eq("lock_lost", lock_a, 1'b0);
        repeat (10) tick(1'b1, 8'h00, 1'b0);
        check_eq("relock", lock_a, 1'b1);
        check_eq("err_after_relock", err_a, 4'h6);

        // Clear, then saturate
        tick(1'b1, 8'h00, 1'b1);
        repeat (20) tick(1'b1, 8'h01, 1'b0);
        check_eq("err_sat", err_a, 4'hF);
        tick(1'b1, 8'h40, 1'b1);
        check_eq("clr_plus_one", err_a, 4'h1);

        // Asynchronous reset while locked
        rst = 1'b1;
        #2;
        check_eq("arst_lock", lock_a, 1'b0);
        check_eq("arst_err", err_a, 4'h0);
        check_eq("arst_pulse", ep_a, 1'b0);
        check_eq("arst_valid", gv_a, 1'b0);
        check_eq("arst_sr", sr_a, 7'h01);
        check_eq("arst_data", gd_a, 8'h00);
        en_a = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
